fetch_pc_unit: RTL

FETCH_PC_UNIT -- requirements
Module: fetch_pc_unit

---
 rtl/fetch_pc_unit_pkg.sv | 28 ++
 rtl/fetch_pc_unit_if_id_reg.sv | 64 ++++++
 rtl/fetch_pc_unit.sv | 120 ++++++++++++
 3 files changed

// File: rtl/fetch_pc_unit_pkg.sv
// Shared fetch-stage definitions: FSM state encoding, PC width, bubble instruction.
// No logic, no latency.
// No backpressure; consumed by fetch_pc_unit and its IF/ID register.
package fetch_pc_unit_pkg;

    localparam int PC_W = 32;

    // addi x0,x0,0 -- the canonical RISC-V NOP used to fill bubbles
    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;

    // Encoding 3 is unused and is treated as BOOT by the FSM
    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_e;

    // Sequential next-PC, wrapping modulo 2^PC_W
    function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
        return pc + PC_W'(4);
    endfunction

    // Force a redirect target onto a word boundary
    function automatic logic [PC_W-1:0] pc_align(input logic [PC_W-1:0] pc);
        return {pc[PC_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_pc_unit_if_id_reg.sv
// IF/ID pipeline register: loads a fetched instruction, a bubble, or holds.
// Latency: one clock edge from load/bubble request to registered output.
// Backpressure: holds contents whenever neither load_i nor bubble_i is set.
module fetch_pc_unit_if_id_reg
    import fetch_pc_unit_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC  = '0,
    parameter logic [31:0]     NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            load_i,
    input  logic            bubble_i,
    input  logic [PC_W-1:0] pc_i,
    input  logic [31:0]     instr_i,
    output logic [PC_W-1:0] pc_o,
    output logic [PC_W-1:0] pc_plus4_o,
    output logic [31:0]     instr_o,
    output logic            valid_o
);

    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] pc_plus4_q, pc_plus4_d;
    logic [31:0]     instr_q, instr_d;
    logic            valid_q, valid_d;

    // Next contents: a real fetch wins over a bubble; a bubble keeps the PC fields
    always_comb begin
        pc_d       = pc_q;
        pc_plus4_d = pc_plus4_q;
        instr_d    = instr_q;
        valid_d    = valid_q;
        if (load_i) begin
            pc_d       = pc_i;
            pc_plus4_d = pc_inc(pc_i);
            instr_d    = instr_i;
            valid_d    = 1'b1;
        end else if (bubble_i) begin
            instr_d    = NOP_INSTR;
            valid_d    = 1'b0;
        end
    end

    // IF/ID storage with asynchronous reset to a bubble at RESET_PC
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q       <= RESET_PC;
            pc_plus4_q <= pc_inc(RESET_PC);
            instr_q    <= NOP_INSTR;
            valid_q    <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            pc_plus4_q <= pc_plus4_d;
            instr_q    <= instr_d;
            valid_q    <= valid_d;
        end
    end

    assign pc_o       = pc_q;
    assign pc_plus4_o = pc_plus4_q;
    assign instr_o    = instr_q;
    assign valid_o    = valid_q;

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch stage: PC register, BOOT/RUN/HALT control FSM, IF/ID register, fetch counter.
// Latency: instruction at PC appears in IF/ID one edge after imem_addr = PC.
// Backpressure: stall holds PC and IF/ID; redirect overrides stall, halt and flush.
module fetch_pc_unit
    import fetch_pc_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt_req,
    input  logic        resume,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc_plus4,
    output logic [31:0] if_id_instr,
    output logic        if_id_valid,
    output logic [31:0] fetch_count,
    output logic        misalign_err,
    output logic [1:0]  fetch_state
);

    fetch_state_e    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [31:0]     count_q, count_d;
    logic            misalign_q, misalign_d;
    logic            ifid_load;
    logic            ifid_bubble;

    // Control decode: redirect > halt_req > stall > flush > normal advance
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        count_d     = count_q;
        misalign_d  = 1'b0;
        ifid_load   = 1'b0;
        ifid_bubble = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (redirect_valid) begin
                    pc_d        = pc_align(redirect_pc);
                    misalign_d  = |redirect_pc[1:0];
                    ifid_bubble = 1'b1;
                end else if (halt_req) begin
                    state_d     = ST_HALT;
                    ifid_bubble = 1'b1;
                end else if (stall) begin
                    // PC held; a concurrent flush still squashes IF/ID
                    ifid_bubble = flush;
                end else if (flush) begin
                    pc_d        = pc_inc(pc_q);
                    ifid_bubble = 1'b1;
                end else begin
                    pc_d        = pc_inc(pc_q);
                    count_d     = count_q + 32'd1;
                    ifid_load   = 1'b1;
                end
            end
            ST_HALT: begin
                ifid_bubble = 1'b1;
                if (redirect_valid) begin
                    state_d    = ST_RUN;
                    pc_d       = pc_align(redirect_pc);
                    misalign_d = |redirect_pc[1:0];
                end else if (resume && !halt_req) begin
                    // First real fetch from the held PC happens on the next edge
                    state_d    = ST_RUN;
                end
            end
            default: begin
                // BOOT (and the unused encoding): one bubble cycle, PC held
                state_d     = ST_RUN;
                ifid_bubble = 1'b1;
            end
        endcase
    end

    // FSM, PC, counter and error pulse registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_PC;
            count_q    <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            count_q    <= count_d;
            misalign_q <= misalign_d;
        end
    end

    fetch_pc_unit_if_id_reg #(
        .RESET_PC  (RESET_PC),
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk_i      (clk),
        .rst_i      (rst),
        .load_i     (ifid_load),
        .bubble_i   (ifid_bubble),
        .pc_i       (pc_q),
        .instr_i    (imem_rdata),
        .pc_o       (if_id_pc),
        .pc_plus4_o (if_id_pc_plus4),
        .instr_o    (if_id_instr),
        .valid_o    (if_id_valid)
    );

    assign imem_addr    = pc_q;
    assign fetch_count  = count_q;
    assign misalign_err = misalign_q;
    assign fetch_state  = state_q;

endmodule
